muldiv_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the EX stage of the MIPS pipeline. It accepts MUL and DIV operations by their 4-bit ALU control code and runs a radix-2 shift-add multiply or a restoring divide over WIDTH cycles. It stalls the pipeline while busy and presents a two-word result (lo/hi) for one cycle on completion.

---
 rtl/muldiv_sequencer_if.sv | 30 +++
 rtl/muldiv_sequencer.sv | 172 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer_if : EX-stage request/result bundle for muldiv_sequencer
// Rev 1.0
// ============================================================================
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALU_Control;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;

  modport master (
    output start, ALU_Control, op_a, op_b, flush,
    input  stall, busy, done, result_lo, result_hi
  );

  modport slave (
    input  start, ALU_Control, op_a, op_b, flush,
    output stall, busy, done, result_lo, result_hi
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer : radix-2 shift-add MUL / restoring DIV over WIDTH cycles.
// Define MULDIV_SIGNED_EN for two's-complement operands.      Rev 1.0
// ============================================================================
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  wire                 clk,
  input  wire                 rst_n,
  muldiv_sequencer_if.slave   bus
);
  localparam int         CW      = $clog2(WIDTH);
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_DIV  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;

  logic             is_mul, is_div, accept;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] step_acc, step_lo, fin_lo, fin_hi;

  assign is_mul = (bus.ALU_Control == OP_MUL);
  assign is_div = (bus.ALU_Control == OP_DIV);
  assign accept = (state_q == S_IDLE) && bus.start && (is_mul || is_div) && !bus.flush;

  // One iteration: acc holds product-high / partial remainder, lo holds
  // multiplier bits shifting out / dividend bits shifting into the quotient.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    if (is_div_q) begin
      step_acc = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo  = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

`ifdef MULDIV_SIGNED_EN
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [2*WIDTH-1:0] prod;

  assign abs_a = bus.op_a[WIDTH-1] ? WIDTH'(-bus.op_a) : bus.op_a;
  assign abs_b = bus.op_b[WIDTH-1] ? WIDTH'(-bus.op_b) : bus.op_b;

  always_comb begin
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    if (accept) begin
      neg_lo_d = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
      neg_hi_d = is_div ? bus.op_a[WIDTH-1] : (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
    end
    prod = {step_acc, step_lo};
    if (neg_lo_q) prod = -prod;
    if (is_div_q) begin
      fin_lo = neg_lo_q ? WIDTH'(-step_lo)  : step_lo;
      fin_hi = neg_hi_q ? WIDTH'(-step_acc) : step_acc;
    end else begin
      fin_lo = prod[WIDTH-1:0];
      fin_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end
`else
  assign abs_a  = bus.op_a;
  assign abs_b  = bus.op_b;
  assign fin_lo = step_lo;
  assign fin_hi = step_acc;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_div_d = is_div;
          opnd_d   = is_div ? abs_b : abs_a;
          lo_d     = is_div ? abs_a : abs_b;
          acc_d    = '0;
          cnt_d    = CW'(WIDTH - 1);
          // Divide by zero bypasses RUN; dividend is reported raw.
          if (is_div && (bus.op_b == '0)) begin
            state_d  = S_DONE;
            res_lo_d = '1;
            res_hi_d = bus.op_a;
          end else begin
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          res_lo_d = fin_lo;
          res_hi_d = fin_hi;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) begin
      state_d  = S_IDLE;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  assign bus.stall     = (state_q == S_RUN) || accept;
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// tb_muldiv_sequencer : directed self-checking bench for muldiv_sequencer
// Rev 1.0
// ============================================================================
module tb_muldiv_sequencer;
  localparam int         W      = 32;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b1011;
  localparam logic [3:0] OP_ADD = 4'b0010;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();
  muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.ALU_Control = 4'b0000;
    bus.op_a        = '0;
    bus.op_b        = '0;
    bus.flush       = 1'b0;
  endtask

  // Issues one op at the next edge and observes it until done (bounded).
  // Cycle 0 is the accept cycle; done_at = -1 if done never appears.
  task automatic drive_op(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int stall_n, output int busy_n, output int done_at,
                          output logic [W-1:0] lo, output logic [W-1:0] hi,
                          output logic busy0, output logic [W-1:0] lo0, output logic [W-1:0] hi0);
    stall_n = 0; busy_n = 0; done_at = -1; lo = '0; hi = '0;
    busy0 = 1'b0; lo0 = '0; hi0 = '0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.ALU_Control = code; bus.op_a = a; bus.op_b = b; bus.flush = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        busy0 = bus.busy; lo0 = bus.result_lo; hi0 = bus.result_hi;
      end
      if (bus.stall) stall_n++;
      if (bus.busy)  busy_n++;
      if (bus.done) begin
        done_at = k; lo = bus.result_lo; hi = bus.result_hi;
        break;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.busy  !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done  !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.result_lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.result_hi); end
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int sn, bn, da; logic [W-1:0] lo, hi, l0, h0; logic b0;
    logic [W-1:0] exp_hi;
`ifdef MULDIV_SIGNED_EN
    exp_hi = 32'hFFFF_FFFF;
`else
    exp_hi = 32'h0000_0006;
`endif
    drive_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, sn, bn, da, lo, hi, b0, l0, h0);
    checks++; if (sn !== 33) begin failures++; $display("FAIL mul_stall_cycles got=%0d exp=33", sn); end
    checks++; if (bn !== 32) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=32", bn); end
    checks++; if (b0 !== 1'b0) begin failures++; $display("FAIL mul_busy_in_accept got=%b exp=0", b0); end
    checks++; if (da !== 33) begin failures++; $display("FAIL mul_done_cycle got=%0d exp=33", da); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_lo got=%h exp=ffffffeb", lo); end
    checks++; if (hi !== exp_hi) begin failures++; $display("FAIL mul_hi got=%h exp=%h", hi, exp_hi); end
  endtask

  task automatic test_div();
    int sn, bn, da; logic [W-1:0] lo, hi, l0, h0; logic b0;
    logic [W-1:0] exp_lo, exp_hi;
    drive_op(OP_DIV, 32'd100, 32'd7, sn, bn, da, lo, hi, b0, l0, h0);
    checks++; if (da !== 33) begin failures++; $display("FAIL div_done_cycle got=%0d exp=33", da); end
    checks++; if (lo !== 32'd14) begin failures++; $display("FAIL div_quot got=%h exp=0000000e", lo); end
    checks++; if (hi !== 32'd2) begin failures++; $display("FAIL div_rem got=%h exp=00000002", hi); end
`ifdef MULDIV_SIGNED_EN
    exp_lo = 32'hFFFF_FFFD; exp_hi = 32'hFFFF_FFFF;
`else
    exp_lo = 32'h7FFF_FFFC; exp_hi = 32'h0000_0001;
`endif
    drive_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, sn, bn, da, lo, hi, b0, l0, h0);
    checks++; if (lo !== exp_lo) begin failures++; $display("FAIL div_neg7_quot got=%h exp=%h", lo, exp_lo); end
    checks++; if (hi !== exp_hi) begin failures++; $display("FAIL div_neg7_rem got=%h exp=%h", hi, exp_hi); end
`ifdef MULDIV_SIGNED_EN
    exp_lo = 32'h8000_0000; exp_hi = 32'h0000_0000;
`else
    exp_lo = 32'h0000_0000; exp_hi = 32'h8000_0000;
`endif
    drive_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, sn, bn, da, lo, hi, b0, l0, h0);
    checks++; if (lo !== exp_lo) begin failures++; $display("FAIL div_min_quot got=%h exp=%h", lo, exp_lo); end
    checks++; if (hi !== exp_hi) begin failures++; $display("FAIL div_min_rem got=%h exp=%h", hi, exp_hi); end
  endtask

  task automatic test_div_zero();
    int sn, bn, da; logic [W-1:0] lo, hi, l0, h0; logic b0;
    drive_op(OP_DIV, 32'd5, 32'd0, sn, bn, da, lo, hi, b0, l0, h0);
    checks++; if (sn !== 1) begin failures++; $display("FAIL dz_stall_cycles got=%0d exp=1", sn); end
    checks++; if (bn !== 0) begin failures++; $display("FAIL dz_busy_cycles got=%0d exp=0", bn); end
    checks++; if (da !== 1) begin failures++; $display("FAIL dz_done_cycle got=%0d exp=1", da); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dz_lo got=%h exp=ffffffff", lo); end
    checks++; if (hi !== 32'd5) begin failures++; $display("FAIL dz_hi got=%h exp=00000005", hi); end
  endtask

  // Runs right after test_div_zero, so the held result is ffffffff / 5.
  task automatic test_flush();
    int sn, bn, da, done_seen; logic [W-1:0] lo, hi, l0, h0; logic b0;
    done_seen = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.ALU_Control = OP_MUL; bus.op_a = 32'd9; bus.op_b = 32'd9;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL flush_busy_before got=%b exp=1", bus.busy); end
    drive_op(OP_MUL, 32'd6, 32'd5, sn, bn, da, lo, hi, b0, l0, h0);
    if (bus.done) done_seen++;
    checks++; if (b0 !== 1'b0) begin failures++; $display("FAIL flush_busy_after got=%b exp=0", b0); end
    checks++; if (l0 !== 32'hFFFF_FFFF || h0 !== 32'd5)
      begin failures++; $display("FAIL flush_result_hold got=%h/%h exp=ffffffff/00000005", l0, h0); end
    checks++; if (done_seen !== 0) begin failures++; $display("FAIL flush_done_pulse got=%0d exp=0", done_seen); end
    checks++; if (da !== 33) begin failures++; $display("FAIL flush_next_done got=%0d exp=33", da); end
    checks++; if (lo !== 32'd30 || hi !== 32'd0)
      begin failures++; $display("FAIL flush_next_result got=%h/%h exp=0000001e/00000000", lo, hi); end
  endtask

  task automatic test_non_op();
    int act;
    act = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.ALU_Control = OP_ADD; bus.op_a = 32'd3; bus.op_b = 32'd4;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.stall || bus.busy || bus.done) act++;
    end
    checks++; if (act !== 0) begin failures++; $display("FAIL nonop_activity got=%0d exp=0", act); end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // start stays high through DONE: the next accept may only come from IDLE.
  task automatic test_back_to_back();
    int da; logic [W-1:0] lo, hi; logic s_done, s_idle, b_idle, b_next;
    logic [W-1:0] exp_hi;
`ifdef MULDIV_SIGNED_EN
    exp_hi = 32'hFFFF_FFFF;
`else
    exp_hi = 32'h0000_0001;
`endif
    da = -1; lo = '0; hi = '0; s_done = 1'bx;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.ALU_Control = OP_MUL; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'd2;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) begin da = k; lo = bus.result_lo; hi = bus.result_hi; s_done = bus.stall; break; end
    end
    @(negedge clk); s_idle = bus.stall; b_idle = bus.busy;
    @(negedge clk); b_next = bus.busy;
    checks++; if (da !== 33) begin failures++; $display("FAIL b2b_done_cycle got=%0d exp=33", da); end
    checks++; if (lo !== 32'hFFFF_FFFE || hi !== exp_hi)
      begin failures++; $display("FAIL b2b_result got=%h/%h exp=fffffffe/%h", lo, hi, exp_hi); end
    checks++; if (s_done !== 1'b0) begin failures++; $display("FAIL b2b_stall_in_done got=%b exp=0", s_done); end
    checks++; if (s_idle !== 1'b1 || b_idle !== 1'b0)
      begin failures++; $display("FAIL b2b_reaccept_idle got=stall%b/busy%b exp=stall1/busy0", s_idle, b_idle); end
    checks++; if (b_next !== 1'b1) begin failures++; $display("FAIL b2b_second_run got=%b exp=1", b_next); end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.ALU_Control = OP_DIV; bus.op_a = 32'd100; bus.op_b = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin failures++; $display("FAIL rstmid_ctrl got=%b%b%b exp=000", bus.stall, bus.busy, bus.done); end
    checks++; if (bus.result_lo !== 32'h0 || bus.result_hi !== 32'h0)
      begin failures++; $display("FAIL rstmid_result got=%h/%h exp=0/0", bus.result_lo, bus.result_hi); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin failures++; $display("FAIL rstmid_idle got=busy%b/done%b exp=busy0/done0", bus.busy, bus.done); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_flush();
    test_non_op();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
